// File: rtl/cfg_chain_ctrl.sv
// cfg_chain_ctrl: bus-filled shadow buffer shifted serially into one of several scan chains with readback and commit
module cfg_chain_ctrl #(
    parameter int          CHAIN_LEN  = 164,
    parameter int          NUM_CHAINS = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           wb_addr,
    input  logic                  valid,
    input  logic                  wen,
    input  logic [3:0]            wstrb,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic [NUM_CHAINS-1:0] chain_sout,
    input  logic [NUM_CHAINS-1:0] chain_sin,
    output logic [NUM_CHAINS-1:0] chain_en,
    output logic [NUM_CHAINS-1:0] chain_latch,
    output logic                  busy,
    output logic                  irq
);
    localparam int WORDS = (CHAIN_LEN + 31) / 32;
    localparam int BW = WORDS * 32;
    localparam int SW = NUM_CHAINS > 1 ? $clog2(NUM_CHAINS) : 1;
    localparam logic [BW-1:0] MASK = {BW{1'b1}} >> (BW - CHAIN_LEN);
    localparam logic [10:0] WEND = 11'(64 + WORDS);
    localparam logic [8:0] NC = 9'(NUM_CHAINS);
    localparam logic [12:0] LAST = 13'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t        state;
    logic [BW-1:0] buf_q, buf_wr, buf_sh;
    logic [7:0]    sel, sel_nx;
    logic          commit, ie, done, err;
    logic [12:0]   cnt;
    logic [9:0]    wi;
    logic          hit, is_ctrl, is_info, is_buf, wr, start_ok, sin;
    logic [31:0]   buf_rd, rd_val;

    assign hit      = wb_addr[31:12] == BASE_ADDR[31:12] && wb_addr[1:0] == 2'b00;
    assign wi       = wb_addr[11:2];
    assign is_ctrl  = hit && wi == 10'd0;
    assign is_info  = hit && wi == 10'd1;
    assign is_buf   = hit && wi >= 10'd64 && {1'b0, wi} < WEND;
    assign wr       = ready & valid & wen;
    assign sel_nx   = wstrb[1] ? wdata[15:8] : sel;
    assign start_ok = wstrb[0] & wdata[0] & ({1'b0, sel_nx} < NC);
    assign sin      = chain_sin[sel[SW-1:0]];
    assign buf_sh   = ((buf_q >> 1) & MASK) | (BW'(sin) << (CHAIN_LEN - 1));
    assign rd_val   = is_ctrl ? {15'b0, ie, sel, 4'b0, err, done, commit, busy}
                    : is_info ? {8'b0, 8'(NUM_CHAINS), 16'(CHAIN_LEN)}
                    : is_buf  ? buf_rd : 32'b0;
    assign chain_sout = chain_en & {NUM_CHAINS{buf_q[0]}};
    assign irq      = done & ie;

    // buffer word readback and byte-strobed merge of the addressed word
    always_comb begin
        buf_wr = buf_q;
        buf_rd = '0;
        for (int w = 0; w < WORDS; w++)
            if (wi == 10'(64 + w)) begin
                buf_rd = buf_q[w*32 +: 32];
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) buf_wr[w*32 + 8*b +: 8] = wdata[8*b +: 8];
            end
        buf_wr = buf_wr & MASK;
    end

    // bus handshake, register writes and the shift/commit sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            buf_q       <= '0;
            sel         <= '0;
            commit      <= 1'b0;
            ie          <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cnt         <= '0;
            ready       <= 1'b0;
            rdata       <= '0;
            chain_en    <= '0;
            chain_latch <= '0;
            busy        <= 1'b0;
        end else begin
            ready       <= valid & ~ready;
            rdata       <= (valid & ~ready) ? rd_val : 32'b0;
            chain_latch <= '0;
            if (wr && is_ctrl) begin
                if (wstrb[2]) ie <= wdata[16];
                if (wstrb[0] && wdata[2]) begin
                    done <= 1'b0;
                    err  <= 1'b0;
                end
            end
            case (state)
                IDLE: begin
                    if (wr && is_buf) buf_q <= buf_wr;
                    if (wr && is_ctrl) begin
                        sel <= sel_nx;
                        if (wstrb[0]) commit <= wdata[1];
                        if (start_ok) begin
                            state    <= SHIFT;
                            cnt      <= '0;
                            chain_en <= NUM_CHAINS'(1) << sel_nx;
                            busy     <= 1'b1;
                        end
                        if (wstrb[0] && wdata[0] && !start_ok) err <= 1'b1;
                    end
                end
                SHIFT: begin
                    buf_q <= buf_sh;
                    cnt   <= cnt + 13'd1;
                    if (cnt == LAST) begin
                        chain_en <= '0;
                        if (commit) begin
                            state       <= LATCH;
                            chain_latch <= NUM_CHAINS'(1) << sel;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
